// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C pad synchroniser, glitch filter and bus-state tracker

// Two-flop synchroniser for an asynchronous pad input; resets to the idle-high bus level.
module i2c_sync2 (
    input  logic clk,
    input  logic rst_an,
    input  logic padIn,
    output logic syncOut
);
    logic [1:0] syncQ;

    // Shift the pad value through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            syncQ <= 2'b11;
        end else begin
            syncQ <= {syncQ[0], padIn};
        end
    end

    assign syncOut = syncQ[1];
endmodule

// Per-line glitch filter: the filtered level only follows the synchronised level once it
// has disagreed for FILT_LEN consecutive cycles. filtNext exposes the value the filter
// will hold after the coming edge, so edge/condition pulses can be registered alongside it.
module i2c_glitch_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_an,
    input  logic syncIn,
    output logic filtOut,
    output logic filtNext
);
    localparam logic [3:0] FILT_LIM = 4'(FILT_LEN);

    logic [3:0] cnt;
    logic [3:0] cntInc;
    logic [3:0] cntNext;
    logic       filtQ;

    // Count disagreeing cycles; accept the new level when the count reaches the limit.
    always_comb begin
        cntInc   = cnt + 4'd1;
        cntNext  = 4'd0;
        filtNext = filtQ;
        if (syncIn != filtQ) begin
            if (cntInc >= FILT_LIM) begin
                filtNext = syncIn;
                cntNext  = 4'd0;
            end else begin
                cntNext  = cntInc;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt   <= 4'd0;
            filtQ <= 1'b1;
        end else begin
            cnt   <= cntNext;
            filtQ <= filtNext;
        end
    end

    assign filtOut = filtQ;
endmodule

// Bus monitor top: levels, edge pulses, START/STOP, bus-busy and SDA hold qualifier.
module i2c_bus_monitor #(
    parameter int FILT_LEN    = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_an,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic [7:0] i2ctrans,
    output logic       active,
    output logic       count_hold_over
);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam logic [15:0] IDLE_LIM  = 16'(IDLE_CYCLES);
    localparam logic        IDLE_EN   = (IDLE_CYCLES != 0);

    logic sclSync;
    logic sdaSync;
    logic sclFilt;
    logic sclFiltNext;
    logic sdaFilt;
    logic sdaFiltNext;

    logic sclRiseQ;
    logic sclFallQ;
    logic startQ;
    logic stopQ;
    logic lastSdaQ;

    logic sclRiseNext;
    logic sclFallNext;
    logic sclStable;
    logic startNext;
    logic stopNext;
    logic lastSdaNext;

    logic [15:0] idleCnt;
    logic [15:0] idleCntNext;
    logic        idleCond;
    logic        idleHit;
    logic        activeNext;

    logic [7:0]  holdCnt;
    logic [7:0]  holdCntNext;

    i2c_sync2 u_sclSync (
        .clk     (clk),
        .rst_an  (rst_an),
        .padIn   (sclIn),
        .syncOut (sclSync)
    );

    i2c_sync2 u_sdaSync (
        .clk     (clk),
        .rst_an  (rst_an),
        .padIn   (sdaIn),
        .syncOut (sdaSync)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sclFilt (
        .clk      (clk),
        .rst_an   (rst_an),
        .syncIn   (sclSync),
        .filtOut  (sclFilt),
        .filtNext (sclFiltNext)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sdaFilt (
        .clk      (clk),
        .rst_an   (rst_an),
        .syncIn   (sdaSync),
        .filtOut  (sdaFilt),
        .filtNext (sdaFiltNext)
    );

    // Decode transitions of the filtered lines; SDA changes only count as START/STOP
    // when SCL is high and not itself changing in the same cycle.
    always_comb begin
        sclRiseNext = ~sclFilt & sclFiltNext;
        sclFallNext = sclFilt & ~sclFiltNext;
        sclStable   = (sclFilt == sclFiltNext);
        startNext   = sclFilt & sclStable & sdaFilt & ~sdaFiltNext;
        stopNext    = sclFilt & sclStable & ~sdaFilt & sdaFiltNext;
        lastSdaNext = sclRiseNext ? sdaFiltNext : lastSdaQ;
    end

    // Register the pulses so they appear in the same cycle as the new filtered level.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            sclRiseQ <= 1'b0;
            sclFallQ <= 1'b0;
            startQ   <= 1'b0;
            stopQ    <= 1'b0;
            lastSdaQ <= 1'b1;
        end else begin
            sclRiseQ <= sclRiseNext;
            sclFallQ <= sclFallNext;
            startQ   <= startNext;
            stopQ    <= stopNext;
            lastSdaQ <= lastSdaNext;
        end
    end

    // Idle timer runs while both lines sit high and restarts on any START/STOP; it
    // saturates once the limit is reached (or at full scale when the timeout is off).
    always_comb begin
        idleCond    = sclFilt & sdaFilt & ~startQ & ~stopQ;
        idleHit     = IDLE_EN && (idleCnt == IDLE_LIM);
        idleCntNext = 16'd0;
        if (idleCond) begin
            if (idleHit || (idleCnt == 16'hFFFF)) begin
                idleCntNext = idleCnt;
            end else begin
                idleCntNext = idleCnt + 16'd1;
            end
        end
    end

    // Bus-busy: START sets, STOP or an expired idle timer clears.
    always_comb begin
        activeNext = active;
        if (startQ) begin
            activeNext = 1'b1;
        end else if (stopQ || idleHit) begin
            activeNext = 1'b0;
        end
    end

    // Hold counter reloads on every SCL fall and counts down to zero.
    always_comb begin
        holdCntNext = holdCnt;
        if (sclFallQ) begin
            holdCntNext = HOLD_LOAD;
        end else if (holdCnt != 8'd0) begin
            holdCntNext = holdCnt - 8'd1;
        end
    end

    // Bus-state registers.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            idleCnt <= 16'd0;
            active  <= 1'b0;
            holdCnt <= 8'd0;
        end else begin
            idleCnt <= idleCntNext;
            active  <= activeNext;
            holdCnt <= holdCntNext;
        end
    end

    assign count_hold_over = (holdCnt == 8'd0);
    assign i2ctrans = {stopQ, startQ, sclRiseQ, sclFallQ, lastSdaQ, sclSync, sdaFilt, sclFilt};
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - scoreboard bench for i2c_bus_monitor
module tb_i2c_bus_monitor;
    logic       clk = 1'b0;
    logic       rst_an;
    logic       sclIn;
    logic       sdaIn;
    logic [7:0] i2ctrans;
    logic       active;
    logic       count_hold_over;

    localparam logic [9:0] ALL   = 10'h3FF;
    localparam logic [9:0] HOLDM = 10'h200;
    localparam logic [9:0] ACTM  = 10'h100;
    localparam logic [9:0] NOLST = 10'h3F7;

    typedef struct {
        int         cyc;
        logic [9:0] mask;
        logic [9:0] val;
        string      name;
    } probe_t;

    probe_t     sbq[$];
    int         nCmp = 0;
    int         nErr = 0;
    int         cyc = 0;
    logic [9:0] obsV;
    bit         matched;

    i2c_bus_monitor #(.FILT_LEN(3), .HOLD_CYCLES(4), .IDLE_CYCLES(1024)) dut (
        .clk             (clk),
        .rst_an          (rst_an),
        .sclIn           (sclIn),
        .sdaIn           (sdaIn),
        .i2ctrans        (i2ctrans),
        .active          (active),
        .count_hold_over (count_hold_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [9:0] vec(input logic h, input logic a, input logic [7:0] t);
        return {h, a, t};
    endfunction

    // Queue an expectation d cycles ahead, kept sorted by cycle; pulse bits always checked.
    task automatic expectAt(input int d, input logic [9:0] m, input logic [9:0] v, input string nm);
        probe_t p;
        int     i;
        p.cyc  = cyc + d;
        p.mask = m | 10'h0F0;
        p.val  = v;
        p.name = nm;
        i = 0;
        while (i < sbq.size() && sbq[i].cyc <= p.cyc) i++;
        sbq.insert(i, p);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compare due expectations, and flag any pulse nobody predicted.
    always @(negedge clk) begin
        obsV    = {count_hold_over, active, i2ctrans};
        matched = 1'b0;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            nCmp++;
            if (sbq[0].cyc < cyc) begin
                nErr++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", sbq[0].name, sbq[0].cyc, cyc);
            end else begin
                matched = 1'b1;
                if ((obsV & sbq[0].mask) !== (sbq[0].val & sbq[0].mask)) begin
                    nErr++;
                    $display("FAIL %s @%0d: got %h required %h (mask %h)", sbq[0].name, cyc,
                             obsV & sbq[0].mask, sbq[0].val & sbq[0].mask, sbq[0].mask);
                end
            end
            void'(sbq.pop_front());
        end
        if (!matched && obsV[7:4] != 4'b0000) begin
            nCmp++;
            nErr++;
            $display("FAIL unexpected_pulse @%0d: got pulses %b required 0000", cyc, obsV[7:4]);
        end
    end

    initial begin
        rst_an = 1'b0;
        sclIn  = 1'b1;
        sdaIn  = 1'b1;
        tick(3);
        expectAt(0, ALL, vec(1, 0, 8'h0F), "in_reset");
        tick(1);
        rst_an = 1'b1;
        tick(20);
        expectAt(0, ALL, vec(1, 0, 8'h0F), "idle_after_reset");
        tick(1);

        // START, then first SCL fall with hold window
        sdaIn = 1'b0;
        expectAt(5, ALL, vec(1, 0, 8'h4D), "start_pulse");
        expectAt(6, ALL, vec(1, 1, 8'h0D), "active_set");
        tick(10);
        sclIn = 1'b0;
        expectAt(5, ALL, vec(1, 1, 8'h18), "sclfall_pulse");
        for (int i = 6; i <= 9; i++) expectAt(i, HOLDM, vec(0, 0, 8'h00), "hold_low");
        expectAt(10, HOLDM, vec(1, 0, 8'h00), "hold_over_again");

        // data bit 0 then data bit 1
        tick(12);
        sclIn = 1'b1;
        expectAt(5, ALL, vec(1, 1, 8'h25), "rise_lastsda0");
        expectAt(6, ALL, vec(1, 1, 8'h05), "lastsda0_held");
        tick(10);
        sclIn = 1'b0;
        expectAt(5, ALL, vec(1, 1, 8'h10), "fall_bit0");
        tick(10);
        sdaIn = 1'b1;
        expectAt(6, ALL, vec(1, 1, 8'h02), "sda_change_scl_low");
        tick(10);
        sclIn = 1'b1;
        expectAt(5, ALL, vec(1, 1, 8'h2F), "rise_lastsda1");

        // glitches on both lines
        tick(10);
        sclIn = 1'b0;
        expectAt(2, 10'h004, vec(0, 0, 8'h00), "rawscl_glitch_lo");
        expectAt(3, 10'h004, vec(0, 0, 8'h00), "rawscl_glitch_lo2");
        expectAt(4, 10'h004, vec(0, 0, 8'h04), "rawscl_glitch_hi");
        tick(2);
        sclIn = 1'b1;
        expectAt(4, ALL, vec(1, 1, 8'h0F), "scl_glitch_filtered");
        tick(8);
        sdaIn = 1'b0;
        tick(1);
        sdaIn = 1'b1;
        expectAt(6, ALL, vec(1, 1, 8'h0F), "sda_glitch_filtered");
        tick(9);

        // repeated START, STOP
        sdaIn = 1'b0;
        expectAt(5, ALL, vec(1, 1, 8'h4D), "repeated_start");
        expectAt(6, ALL, vec(1, 1, 8'h0D), "repeated_start_active");
        tick(10);
        sdaIn = 1'b1;
        expectAt(5, ALL, vec(1, 1, 8'h8F), "stop_pulse");
        expectAt(6, ALL, vec(1, 0, 8'h0F), "active_cleared");

        // simultaneous rise, then idle timeout
        tick(10);
        sdaIn = 1'b0;
        expectAt(5, ALL, vec(1, 0, 8'h4D), "start2");
        tick(10);
        sclIn = 1'b0;
        expectAt(5, ALL, vec(1, 1, 8'h18), "fall2");
        tick(10);
        sclIn = 1'b1;
        sdaIn = 1'b1;
        expectAt(5, NOLST, vec(1, 1, 8'h2F), "simul_rise_only");
        expectAt(6, NOLST, vec(1, 1, 8'h0F), "simul_no_stop");
        expectAt(1000, ACTM, vec(0, 1, 8'h00), "idle_not_yet");
        expectAt(1040, ACTM, vec(0, 0, 8'h00), "idle_timeout");
        tick(1045);

        // STOP while inactive
        sclIn = 1'b0;
        sdaIn = 1'b0;
        expectAt(5, NOLST, vec(1, 0, 8'h18), "simul_fall_inactive");
        tick(10);
        sclIn = 1'b1;
        expectAt(5, ALL, vec(1, 0, 8'h25), "rise_inactive");
        tick(10);
        sdaIn = 1'b1;
        expectAt(5, ALL, vec(1, 0, 8'h87), "stop_inactive");
        expectAt(6, ALL, vec(1, 0, 8'h07), "stays_inactive");

        // reset mid-byte, then fresh START
        tick(10);
        sdaIn = 1'b0;
        expectAt(5, ALL, vec(1, 0, 8'h45), "start3");
        tick(10);
        sclIn = 1'b0;
        expectAt(5, ALL, vec(1, 1, 8'h10), "fall3");
        expectAt(6, HOLDM | ACTM, vec(0, 1, 8'h00), "hold_mid_byte");
        tick(7);
        rst_an = 1'b0;
        sclIn  = 1'b1;
        sdaIn  = 1'b1;
        expectAt(0, ALL, vec(1, 0, 8'h0F), "async_reset");
        tick(3);
        rst_an = 1'b1;
        tick(5);
        expectAt(0, ALL, vec(1, 0, 8'h0F), "post_reset_idle");
        tick(1);
        sdaIn = 1'b0;
        expectAt(5, ALL, vec(1, 0, 8'h4D), "post_reset_start");
        expectAt(6, ALL, vec(1, 1, 8'h0D), "post_reset_active");
        tick(20);

        nCmp++;
        if (sbq.size() != 0) begin
            nErr++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Front-end stage directly upstream of the I2C master FSM.
- Synchronises and deglitches the raw SCL/SDA pad inputs and produces the i2ctrans transition vector: levels, edges, START and STOP.
- Tracks bus-busy (active) and generates the data hold-time qualifier (count_hold_over) consumed by the master.

Parameters:
FILT_LEN, 3, consecutive stable cycles before a synchronised level is accepted (1..15)
HOLD_CYCLES, 4, clk cycles after a filtered SCL fall before count_hold_over reasserts (0..255; 0 = always over)
IDLE_CYCLES, 1024, cycles of SCL=SDA=1 that force active low; 0 disables (max 65535)

Ports:
clk  input  1  system clock
rst_an  input  1  asynchronous active-low reset
sclIn  input  1  raw SCL pad value, asynchronous
sdaIn  input  1  raw SDA pad value, asynchronous
i2ctrans  output  8  bus transition vector; bit map under Behaviour
active  output  1  bus busy: START seen, STOP not yet seen
count_hold_over  output  1  minimum SDA hold time after SCL fall has elapsed

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_an. All flops reset asynchronously.
- Reset values: synchronisers=1, filtered SCL/SDA=1, i2ctrans=8'b0000_1111, active=0, count_hold_over=1, all counters 0.
- i2ctrans bit map:
  [0] SCL filtered
  [1] SDA filtered
  [2] RAWSCL, synchronised SCL before the filter
  [3] LASTSDA
  [4] SCLFALL pulse
  [5] SCLRISE pulse
  [6] START pulse
  [7] STOP pulse
- Synchronisers: each of sclIn and sdaIn passes through a 2-flop synchroniser. RAWSCL is the second flop of the SCL synchroniser.
- Glitch filter, per line:
  - 4-bit counter clears whenever the synchronised value equals the filtered value.
  - Otherwise it increments. When it reaches FILT_LEN, the filtered value takes the synchronised value and the counter clears.
  - A pulse shorter than FILT_LEN cycles never reaches the filtered output.
- Latency: pad edge to filtered level change or pulse = 2 + FILT_LEN cycles.
- Edge pulses: SCLFALL / SCLRISE are high for exactly one cycle, the cycle in which filtered SCL changes. Registered outputs, asserted together with the new level.
- LASTSDA: captures filtered SDA on every SCLRISE and holds between rises.
- START: one-cycle pulse when filtered SDA goes 1->0 while filtered SCL is 1 and SCL does not change in that cycle.
- STOP: one-cycle pulse when filtered SDA goes 0->1 while filtered SCL is 1 and SCL does not change in that cycle.
- Simultaneous SCL and SDA change in one cycle: edge pulses only; no START/STOP.
- active:
  - Set on START. Cleared on STOP.
  - Repeated START while active leaves it at 1.
  - STOP while inactive leaves it at 0.
- Idle timeout (IDLE_CYCLES != 0): a 16-bit counter increments while filtered SCL=SDA=1 and clears otherwise, and on any START/STOP. When it reaches IDLE_CYCLES it forces active=0 and saturates. It does not generate STOP.
- Hold counter (8-bit):
  - Loaded with HOLD_CYCLES on SCLFALL; otherwise decrements to 0 and holds.
  - count_hold_over = (counter==0), combinational from the counter register.
  - count_hold_over drops in the cycle after SCLFALL and is high again HOLD_CYCLES cycles after that drop.
  - SCLFALL during an active count reloads the counter.
- Reset mid-transfer: all state returns to reset values immediately. The first post-reset START is detected normally; bus history before reset is discarded.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release, both pads high for 20 cycles -> i2ctrans=8'h0F, active=0, count_hold_over=1, no pulses.
- SDA 1->0 with SCL=1, then 10 cycles later SCL 1->0 (FILT_LEN=3) -> START pulse 5 cycles after SDA edge and active=1 in the following cycle; SCLFALL pulse 5 cycles after SCL edge; count_hold_over low for exactly 4 cycles (HOLD_CYCLES=4).
- Data bit: SDA=0 then SCL rise -> LASTSDA=0 after SCLRISE. Then SCL fall, SCL rise with SDA=1 -> LASTSDA=1.
- Glitches: 2-cycle low pulse on SCL and 1-cycle pulse on SDA -> filtered bits, SCLFALL, START and STOP unchanged. RAWSCL follows the SCL glitch after 2 cycles.
- SCL=1, SDA 0->1 while active -> one STOP pulse, active=0. SCL and SDA rising in the same cycle -> SCLRISE only, no STOP, active stays 1.
- active=1, bus held idle (SCL=SDA=1) for IDLE_CYCLES=1024 cycles without STOP -> active=0 at cycle 1024. rst_an pulsed low mid-byte -> outputs return to reset values asynchronously.
